mem_nr1w_be: RTL and testbench
==============================

// Module: mem_nr1w_be
// PURPOSE
//   Parametrised multi-read, single-write synchronous memory for emulation memory tests.
//   Generalises the fixed 8x80 one-read/one-write test memory in four ways:
//     - NUM_RD independent read ports, each with a read enable and a registered output;
//     - byte-lane write strobes;
//     - selectable read-during-write mode;
//     - per-lane "written" tracking, so unwritten data reads as zero after reset.
//   Sits between test-harness interface ports and the emulated RAM model.
// PARAMETERS
//   DATA_WIDTH  80  word width in bits
//   ADDR_WIDTH  3   address width; DEPTH = 2**ADDR_WIDTH words
//   NUM_RD      2   number of read ports (>=1)
//   BYTE_WIDTH  8   lane width; NB = ceil(DATA_WIDTH/BYTE_WIDTH); last lane may be partial
//   RDW_MODE    0   same-address read+write in one cycle: 0 = old data, 1 = new (merged) data
// PORTS
//   clk       in   1                    single clock; all state on posedge
//   rst_n     in   1                    asynchronous, active-low reset
//   rd_en     in   NUM_RD               per-port read request
//   rd_addr   in   NUM_RD*ADDR_WIDTH    port i address = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   out  NUM_RD*DATA_WIDTH    port i data, registered
//   rd_valid  out  NUM_RD               port i: every lane of the read word had been written
//   wr_en     in   1                    write request
//   wr_addr   in   ADDR_WIDTH           write address
//   wr_strb   in   NB                   lane enables; lane k = bits [k*BYTE_WIDTH +: BYTE_WIDTH]
//   wr_data   in   DATA_WIDTH           write data
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous):
//       - rd_data = 0 and rd_valid = 0 on all ports; all DEPTH*NB written bits cleared.
//       - Storage array is not reset.
//       - Takes effect immediately; a write coincident with reset assertion is discarded.
//       - First capture occurs at the first posedge after rst_n is sampled high.
//   - Write: at posedge with wr_en=1, lane k of mem[wr_addr] <= wr_data lane k,
//     and written[wr_addr][k] <= 1, for each k with wr_strb[k]=1.
//       - wr_en=1 with wr_strb=0 is a no-op.
//       - Un-strobed lanes and their written bits are unchanged.
//   - Read, latency 1: at posedge with rd_en[i]=1, port i captures word W for rd_addr[i]:
//       - rd_data[i] lane k = W lane k if written[addr][k], else 0.
//       - rd_valid[i] = AND over k of written[addr][k].
//   - Hold: with rd_en[i]=0, rd_data[i] and rd_valid[i] hold their previous values,
//     even if the addressed word is written later.
//   - Read-during-write (rd_en[i] & wr_en & rd_addr[i]==wr_addr, same edge):
//       - RDW_MODE=0: W and the written bits are the pre-write contents.
//       - RDW_MODE=1: strobed lanes take wr_data and count as written;
//         other lanes take the pre-write contents and written bits.
//   - Ports are independent: multiple ports may read the same address in one cycle;
//     each sees identical results under the rules above.
//   - Address wrap: DEPTH is a power of two, so every address is in range; no error path.
//   - Partial top lane: only its DATA_WIDTH-(NB-1)*BYTE_WIDTH low bits exist.
//   - No combinational path from any input to rd_data or rd_valid.
// TESTING
//   1. Reset, then rd_en[0]=1, rd_addr=5 -> next cycle rd_data[0]=0, rd_valid[0]=0.
//   2. Write addr 3, strb=10'h3FF, data 80'h1234_5678_9ABC_DEF0_1122; next cycle read
//      addr 3 on both ports -> both return that data, rd_valid=2'b11.
//   3. After reset, write addr 2, strb=10'h001, data 80'hFF -> read addr 2:
//      rd_data=80'hFF, rd_valid=0. Then write strb=10'h3FE -> rd_valid=1.
//   4. Addr 4 holds A; same cycle write B (full strobe) and read addr 4:
//      RDW_MODE=0 -> A; RDW_MODE=1 -> B. Next read of addr 4 -> B in both modes.
//   5. Read addr 1 (returns X), deassert rd_en, then write addr 1 -> rd_data holds X;
//      re-read -> new value.
//   6. Write all 8 entries; pulse rst_n low mid-stream with wr_en=1 ->
//      outputs 0 immediately; all reads return 0 / rd_valid=0 until rewritten.

Source files
------------

// File: rtl/mem_nr1w_be.sv
// -----------------------------------------------------------------------------
// mem_nr1w_be
//   Multi-read, single-write synchronous memory with byte-lane write strobes,
//   per-lane "written" tracking and a selectable read-during-write mode.
//   Lanes that have never been written since reset read back as zero, and a
//   read port reports rd_valid only when every lane of the word is written.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH
//   NUM_RD      number of read ports (>= 1)
//   BYTE_WIDTH  lane width; the top lane may be partial
//   RDW_MODE    same-address read+write: 0 = old data, 1 = merged new data
//
// Ports
//   clk       clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   rd_en     [NUM_RD]              per-port read request
//   rd_addr   [NUM_RD*ADDR_WIDTH]   port i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   [NUM_RD*DATA_WIDTH]   port i registered data
//   rd_valid  [NUM_RD]              port i: all lanes of the read word written
//   wr_en     write request
//   wr_addr   [ADDR_WIDTH]          write address
//   wr_strb   [NB]                  lane enables
//   wr_data   [DATA_WIDTH]          write data
// -----------------------------------------------------------------------------
module mem_nr1w_be #(
  parameter int DATA_WIDTH = 80,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_RD     = 2,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  localparam int NB        = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [NB-1:0]                wr_strb,
  input  logic [DATA_WIDTH-1:0]        wr_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Expand one bit per lane into a bit mask over the word. Bits of a partial
  // top lane beyond DATA_WIDTH simply do not exist.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NB-1:0] lanes);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < BYTE_WIDTH; j++) begin
        if (k * BYTE_WIDTH + j < DATA_WIDTH) m[k * BYTE_WIDTH + j] = lanes[k];
      end
    end
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] mem     [DEPTH];
  logic [NB-1:0]         written [DEPTH];
  logic [DATA_WIDTH-1:0] wr_mask;

  assign wr_mask = lane_mask(wr_strb);

  // NOTE: the storage array has no reset; clearing it would cost a reset net
  // on every bit. Freshly reset contents are hidden by the written bits
  // instead, which is also why a write landing while rst_n is low is
  // unobservable: its written bits stay cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) written[a] <= '0;
    end else if (wr_en) begin
      written[wr_addr] <= written[wr_addr] | wr_strb;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] word;
    logic [NB-1:0]         wbits;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Word and written bits as seen by this port at the coming edge. In
    // new-data mode a same-address write is merged lane by lane.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
      word  = mem[addr];
      wbits = written[addr];
      if (RDW_MODE == 1 && wr_en && addr == wr_addr) begin
        word  = (word & ~wr_mask) | (wr_data & wr_mask);
        wbits = wbits | wr_strb;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (rd_en[i]) begin
        data_q  <= word & lane_mask(wbits);
        valid_q <= &wbits;
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign rd_valid[i]                         = valid_q;
  end

endmodule

// File: tb/tb_mem_nr1w_be.sv
// -----------------------------------------------------------------------------
// tb_mem_nr1w_be
//   Directed bench for mem_nr1w_be. Two instances share all inputs: u_old
//   uses old-data read-during-write, u_new uses merged new data. A table of
//   single-cycle vectors carries expectations for both, followed by hand
//   sequences for read hold and mid-stream asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mem_nr1w_be;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   rd_en = '0;
  logic [5:0]   rd_addr = '0;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = '0;
  logic [9:0]   wr_strb = '0;
  logic [79:0]  wr_data = '0;
  logic [159:0] rd_data_old, rd_data_new;
  logic [1:0]   rd_valid_old, rd_valid_new;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_nr1w_be #(.RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_old), .rd_valid(rd_valid_old), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data)
  );

  mem_nr1w_be #(.RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_new), .rd_valid(rd_valid_new), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data)
  );

  typedef struct {
    logic [1:0]  re;
    logic [2:0]  a0, a1;
    logic        we;
    logic [2:0]  wa;
    logic [9:0]  st;
    logic [79:0] wd;
    logic [79:0] o0, o1;   // expected port data, old-data mode
    logic [1:0]  ov;
    logic [79:0] n0, n1;   // expected port data, new-data mode
    logic [1:0]  nv;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1,
    input logic we, input logic [2:0] wa, input logic [9:0] st, input logic [79:0] wd,
    input logic [79:0] o0, input logic [79:0] o1, input logic [1:0] ov,
    input logic [79:0] n0, input logic [79:0] n1, input logic [1:0] nv);
    vec_t v;
    v.re = re; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.st = st; v.wd = wd;
    v.o0 = o0; v.o1 = o1; v.ov = ov; v.n0 = n0; v.n1 = n1; v.nv = nv;
    return v;
  endfunction

  function automatic logic [79:0] pat(input int a);
    logic [7:0] b;
    b = 8'hA0 | 8'(a);
    return {10{b}};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, then return just after the
  // posedge that consumes them.
  task automatic apply(input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1,
                       input logic we, input logic [2:0] wa, input logic [9:0] st,
                       input logic [79:0] wd);
    @(negedge clk);
    rd_en   = re;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_strb = st;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " old data"},  rd_data_old,  '0);
    check({name, " old valid"}, {158'd0, rd_valid_old}, '0);
    check({name, " new data"},  rd_data_new,  '0);
    check({name, " new valid"}, {158'd0, rd_valid_new}, '0);
  endtask

  localparam logic [79:0] DA  = 80'h1234_5678_9ABC_DEF0_1122;
  localparam logic [79:0] DM  = 80'h0102_0304_0506_0708_09FF;
  localparam logic [79:0] DC  = 80'hCAFE_0000_1111_2222_3333;
  localparam logic [79:0] DB  = 80'h0BAD_BEEF_5555_6666_7777;
  localparam logic [79:0] DE  = 80'hFFFF_FFFF_FFFF_FFFF_ABCD;
  localparam logic [79:0] DX  = 80'h1111_2222_3333_4444_5555;
  localparam logic [79:0] DY  = 80'h9999_8888_7777_6666_5555;
  localparam logic [79:0] ONE = {80{1'b1}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // re, a0, a1, we, wa, strb, wd, | old: d0, d1, v | new: d0, d1, v
    vt.push_back(mk(2'b01, 5, 0, 0, 0, 10'h000, '0,   '0, '0, 2'b00,   '0, '0, 2'b00));
    vt.push_back(mk(2'b00, 0, 0, 1, 3, 10'h3FF, DA,   '0, '0, 2'b00,   '0, '0, 2'b00));
    vt.push_back(mk(2'b11, 3, 3, 0, 0, 10'h000, '0,   DA, DA, 2'b11,   DA, DA, 2'b11));
    vt.push_back(mk(2'b00, 0, 0, 1, 2, 10'h001, 80'hFF, DA, DA, 2'b11, DA, DA, 2'b11));
    vt.push_back(mk(2'b11, 2, 2, 0, 0, 10'h000, '0,   80'hFF, 80'hFF, 2'b00, 80'hFF, 80'hFF, 2'b00));
    vt.push_back(mk(2'b00, 0, 0, 1, 2, 10'h3FE, 80'h0102_0304_0506_0708_09EE,
                    80'hFF, 80'hFF, 2'b00, 80'hFF, 80'hFF, 2'b00));
    vt.push_back(mk(2'b11, 2, 3, 0, 0, 10'h000, '0,   DM, DA, 2'b11,   DM, DA, 2'b11));
    vt.push_back(mk(2'b00, 0, 0, 1, 4, 10'h3FF, DC,   DM, DA, 2'b11,   DM, DA, 2'b11));
    // same-address read and full write: old mode sees C, new mode sees B
    vt.push_back(mk(2'b11, 4, 4, 1, 4, 10'h3FF, DB,   DC, DC, 2'b11,   DB, DB, 2'b11));
    vt.push_back(mk(2'b11, 4, 4, 0, 0, 10'h000, '0,   DB, DB, 2'b11,   DB, DB, 2'b11));
    // same-address partial write into an unwritten word
    vt.push_back(mk(2'b11, 6, 6, 1, 6, 10'h003, DE,   '0, '0, 2'b00,   80'hABCD, 80'hABCD, 2'b00));
    vt.push_back(mk(2'b01, 6, 0, 0, 0, 10'h000, '0,   80'hABCD, '0, 2'b00, 80'hABCD, 80'hABCD, 2'b00));
    // write with no strobes is a no-op, even on the read address
    vt.push_back(mk(2'b10, 0, 3, 1, 3, 10'h000, ONE,  80'hABCD, DA, 2'b10, 80'hABCD, DA, 2'b10));
    vt.push_back(mk(2'b01, 3, 0, 0, 0, 10'h000, '0,   DA, DA, 2'b11,   DA, DA, 2'b11));
    // strobes without wr_en must neither write nor merge
    vt.push_back(mk(2'b01, 3, 0, 0, 3, 10'h3FF, ONE,  DA, DA, 2'b11,   DA, DA, 2'b11));

    // Reset: asynchronous assertion clears outputs before any clock edge.
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].re, vt[i].a0, vt[i].a1, vt[i].we, vt[i].wa, vt[i].st, vt[i].wd);
      check($sformatf("vec%0d old data", i),  rd_data_old, {vt[i].o1, vt[i].o0});
      check($sformatf("vec%0d old valid", i), {158'd0, rd_valid_old}, {158'd0, vt[i].ov});
      check($sformatf("vec%0d new data", i),  rd_data_new, {vt[i].n1, vt[i].n0});
      check($sformatf("vec%0d new valid", i), {158'd0, rd_valid_new}, {158'd0, vt[i].nv});
    end

    // Hold: output keeps the old word after rd_en drops, even across a write.
    apply(2'b00, 0, 0, 1, 1, 10'h3FF, DX);
    apply(2'b01, 1, 0, 0, 0, 10'h000, '0);
    check("hold read old",   rd_data_old[79:0], DX);
    check("hold read new",   rd_data_new[79:0], DX);
    apply(2'b00, 1, 0, 1, 1, 10'h3FF, DY);
    check("hold kept old",   rd_data_old[79:0], DX);
    check("hold kept new",   rd_data_new[79:0], DX);
    check("hold valid",      {158'd0, rd_valid_old[0]}, 160'd1);
    apply(2'b01, 1, 0, 0, 0, 10'h000, '0);
    check("hold reread old", rd_data_old[79:0], DY);
    check("hold reread new", rd_data_new[79:0], DY);

    // Mid-stream reset: fill memory, then drop rst_n while a write is pending.
    for (int a = 0; a < 8; a++) apply(2'b00, 0, 0, 1, 3'(a), 10'h3FF, pat(a));
    apply(2'b11, 7, 0, 0, 0, 10'h000, '0);
    check("fill read old p0", rd_data_old[79:0], pat(7));
    check("fill read new p1", rd_data_new[159:80], pat(0));
    @(negedge clk);
    rd_en   = 2'b11;
    rd_addr = {3'd5, 3'd7};
    wr_en   = 1'b1;
    wr_addr = 3'd7;
    wr_strb = 10'h3FF;
    wr_data = ONE;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge clk);
    #1 check_all_zero("reset hold");
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = '0;
    wr_en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      apply(2'b11, 3'(a), 3'(7 - a), 0, 0, 10'h000, '0);
      check_all_zero($sformatf("post reset addr%0d", a));
    end
    apply(2'b00, 0, 0, 1, 7, 10'h3FF, DB);
    apply(2'b01, 7, 0, 0, 0, 10'h000, '0);
    check("rewrite data old",  rd_data_old[79:0], DB);
    check("rewrite data new",  rd_data_new[79:0], DB);
    check("rewrite valid old", {158'd0, rd_valid_old}, 160'd1);
    check("rewrite valid new", {158'd0, rd_valid_new}, 160'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
